// File: rtl/alut_age_checker9_pkg.sv
// alut_pkg9: shared constants, entry field map and aging FSM state type for the ALUT age engine
// Entry layout: [82]=valid, [81:50]=last-seen time, [49:48]=port, [47:0]=MAC
package alut_pkg9;
    localparam int DW9        = 83;
    localparam int DD9        = 256;
    localparam int AW9        = 8;
    localparam int TW9        = 32;
    localparam int CW9        = AW9 + 1;
    localparam int VALID_BIT9 = 82;
    localparam int TS_MSB9    = 81;
    localparam int TS_LSB9    = 50;
    localparam int PORT_MSB9  = 49;
    localparam int PORT_LSB9  = 48;
    localparam int MAC_MSB9   = 47;
    localparam int MAC_LSB9   = 0;
    localparam logic [AW9-1:0] LAST_IDX9 = AW9'(DD9 - 1);
    localparam logic [CW9-1:0] MAX_CNT9  = CW9'(DD9);
    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_WAIT,
        S_CHK,
        S_WR,
        S_NEXT,
        S_DONE
    } age_state_t;
endpackage

// File: rtl/alut_age_checker9_cmp.sv
// alut_age_cmp9: combinational wrap-safe age compare of one entry timestamp against the time base
// Ports: ts (entry last-seen time), now (current time), thr (threshold, 0 disables),
//        aged (age strictly above a non-zero threshold)
module alut_age_cmp9
    import alut_pkg9::*;
(
    input  logic [TW9-1:0] ts,
    input  logic [TW9-1:0] now,
    input  logic [TW9-1:0] thr,
    output logic           aged
);
    logic [TW9-1:0] age;
    // modulo-2^TW9 difference stays correct across a time base wrap
    assign age  = now - ts;
    assign aged = (thr != '0) && (age > thr);
endmodule

// File: rtl/alut_age_checker9.sv
// alut_age_checker9: sweeps the ALUT entry RAM over its age port and invalidates stale entries
// Ports: pclk9/n_p_reset9 clock and async active-low reset; sweep_start9 sweep request;
//        curr_time9/age_threshold9 time base and max age; mem_addr_add9/mem_write_add9 snooped
//        address-checker writes; mem_read_data_age9, mem_addr_age9, mem_write_age9,
//        mem_write_data_age9 age-port RAM interface; sweep_busy9, sweep_done9, aged_count9 status
module alut_age_checker9
    import alut_pkg9::*;
(
    input  logic           pclk9,
    input  logic           n_p_reset9,
    input  logic           sweep_start9,
    input  logic [TW9-1:0] curr_time9,
    input  logic [TW9-1:0] age_threshold9,
    input  logic [AW9-1:0] mem_addr_add9,
    input  logic           mem_write_add9,
    input  logic [DW9-1:0] mem_read_data_age9,
    output logic [AW9-1:0] mem_addr_age9,
    output logic           mem_write_age9,
    output logic [DW9-1:0] mem_write_data_age9,
    output logic           sweep_busy9,
    output logic           sweep_done9,
    output logic [AW9:0]   aged_count9
);
    age_state_t     state, nxt;
    logic [1:0]     rst_sync;
    logic           rst_n;
    logic [AW9-1:0] idx;
    logic [AW9:0]   count;
    logic [DW9-1:0] entry;
    logic           ts_aged, aged, collision;
    // reset asserts immediately but releases on a clock edge
    always_ff @(posedge pclk9 or negedge n_p_reset9) begin
        if (!n_p_reset9) rst_sync <= '0;
        else rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_n = rst_sync[1];
    alut_age_cmp9 u_cmp (
        .ts   (mem_read_data_age9[TS_MSB9:TS_LSB9]),
        .now  (curr_time9),
        .thr  (age_threshold9),
        .aged (ts_aged)
    );
    assign aged = mem_read_data_age9[VALID_BIT9] && ts_aged;
    // address checker refreshed the entry under inspection: its read data is stale
    assign collision = mem_write_add9 && (mem_addr_add9 == idx) &&
                       (state == S_WAIT || state == S_CHK || state == S_WR);
    always_comb begin
        nxt = state;
        case (state)
            S_IDLE:  nxt = sweep_start9 ? S_RD : S_IDLE;
            S_RD:    nxt = S_WAIT;
            S_WAIT:  nxt = collision ? S_RD : S_CHK;
            S_CHK:   nxt = collision ? S_RD : (aged ? S_WR : S_NEXT);
            S_WR:    nxt = collision ? S_RD : S_NEXT;
            S_NEXT:  nxt = (idx == LAST_IDX9) ? S_DONE : S_RD;
            S_DONE:  nxt = S_IDLE;
            default: nxt = S_IDLE;
        endcase
    end
    always_ff @(posedge pclk9 or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            idx   <= '0;
            count <= '0;
            entry <= '0;
        end else begin
            state <= nxt;
            if (state == S_IDLE && sweep_start9) begin
                idx   <= '0;
                count <= '0;
            end
            if (state == S_NEXT && idx != LAST_IDX9) idx <= idx + 1'b1;
            if (state == S_WR && !collision && count != MAX_CNT9) count <= count + 1'b1;
            if (state == S_CHK)
                entry <= {1'b0, mem_read_data_age9[TS_MSB9:TS_LSB9],
                          mem_read_data_age9[PORT_MSB9:PORT_LSB9],
                          mem_read_data_age9[MAC_MSB9:MAC_LSB9]};
        end
    end
    assign mem_addr_age9       = (state == S_IDLE) ? '0 : idx;
    assign mem_write_age9      = (state == S_WR) && !collision;
    assign mem_write_data_age9 = mem_write_age9 ? entry : '0;
    assign sweep_busy9         = (state != S_IDLE);
    assign sweep_done9         = (state == S_DONE);
    assign aged_count9         = count;
endmodule

// File: tb/tb_alut_age_checker9.sv
// tb_alut_age_checker9: self-checking bench with a RAM model, vector table, random sweeps and corner sequences
module tb_alut_age_checker9;
    import alut_pkg9::*;
    typedef struct {
        logic        v;
        logic [31:0] ts;
        logic [31:0] now;
        logic [31:0] thr;
        int          aged;
    } vec_t;
    logic           clk = 1'b0;
    logic           rst_n, start, add_wr;
    logic [31:0]    now, thr;
    logic [7:0]     add_addr;
    logic [82:0]    add_data, rd_data, wdata;
    logic [7:0]     addr;
    logic           wr, busy, done;
    logic [8:0]     cnt;
    logic [82:0]    mem [256];
    logic [82:0]    shadow [256];
    vec_t           vecs [9];
    int             n_chk = 0, n_pass = 0;
    int             busy_tot = 0, done_tot = 0, wr_tot = 0, wr7_tot = 0, first_addr = -1;
    logic           prev_busy = 1'b0;
    int             b0, d0, w0, w70;
    always #5 clk = ~clk;
    alut_age_checker9 dut (
        .pclk9               (clk),
        .n_p_reset9          (rst_n),
        .sweep_start9        (start),
        .curr_time9          (now),
        .age_threshold9      (thr),
        .mem_addr_add9       (add_addr),
        .mem_write_add9      (add_wr),
        .mem_read_data_age9  (rd_data),
        .mem_addr_age9       (addr),
        .mem_write_age9      (wr),
        .mem_write_data_age9 (wdata),
        .sweep_busy9         (busy),
        .sweep_done9         (done),
        .aged_count9         (cnt)
    );
    always @(posedge clk) begin
        if (wr) mem[addr] <= wdata;
        if (add_wr) mem[add_addr] <= add_data;
        rd_data <= mem[addr];
    end
    always @(negedge clk) begin
        if (busy) busy_tot++;
        if (done) done_tot++;
        if (wr) wr_tot++;
        if (wr && addr == 8'd7) wr7_tot++;
        if (busy && !prev_busy) first_addr = int'(addr);
        prev_busy = busy;
    end
    task automatic chk(input string name, input logic [82:0] got, input logic [82:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic add_write(input int a, input logic [82:0] d);
        add_addr = 8'(a);
        add_data = d;
        add_wr   = 1'b1;
        tick();
        add_wr   = 1'b0;
    endtask
    task automatic start_sweep();
        b0 = busy_tot; d0 = done_tot; w0 = wr_tot; w70 = wr7_tot;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask
    task automatic wait_done();
        int c;
        for (c = 0; c < 3000; c++) begin
            if (!busy && done_tot > d0) break;
            tick();
        end
        chk("sweep_timeout", c >= 3000, 0);
        tick();
    endtask
    task automatic check_sweep(input string tag, input int eb, input int ew, input int ec);
        chk({tag, "_busy_cycles"}, busy_tot - b0, eb);
        chk({tag, "_done_pulses"}, done_tot - d0, 1);
        chk({tag, "_age_writes"}, wr_tot - w0, ew);
        chk({tag, "_aged_count"}, cnt, ec);
    endtask
    // age of an entry as a non-negative distance on a 2^32 circular time base
    function automatic logic ref_aged(input logic [82:0] e, input logic [31:0] n, input logic [31:0] t);
        longint unsigned ts_l = 64'(e[81:50]);
        longint unsigned n_l  = 64'(n);
        longint unsigned age  = (n_l >= ts_l) ? n_l - ts_l : n_l + 64'h1_0000_0000 - ts_l;
        return e[82] && t != 0 && age > 64'(t);
    endfunction
    function automatic logic [82:0] invalidate(input logic [82:0] e);
        logic [82:0] r = e;
        r[82] = 1'b0;
        return r;
    endfunction
    task automatic check_idle_outputs(input string tag);
        chk({tag, "_addr"}, addr, 0);
        chk({tag, "_wr"}, wr, 0);
        chk({tag, "_wdata"}, wdata, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_count"}, cnt, 0);
    endtask
    initial begin
        logic [82:0] e, e7, e9, n7, n9, e40;
        int          found, n_aged, mism, mode;
        vecs[0] = '{1'b1, 32'd100,        32'd1100,       32'd999,        1};
        vecs[1] = '{1'b1, 32'd100,        32'd1100,       32'd1000,       0};
        vecs[2] = '{1'b1, 32'hFFFF_FFF0,  32'h10,         32'd16,         1};
        vecs[3] = '{1'b1, 32'hFFFF_FFF0,  32'h10,         32'd32,         0};
        vecs[4] = '{1'b1, 32'd100,        32'd1100,       32'd0,          0};
        vecs[5] = '{1'b1, 32'd0,          32'hFFFF_FFFF,  32'hFFFF_FFFE,  1};
        vecs[6] = '{1'b1, 32'd500,        32'd500,        32'd1,          0};
        vecs[7] = '{1'b1, 32'd10,         32'd5,          32'd100,        1};
        vecs[8] = '{1'b0, 32'd0,          32'd1000,       32'd1,          0};
        rst_n = 1'b0; start = 1'b0; add_wr = 1'b0; add_addr = '0; add_data = '0;
        now = '0; thr = '0;
        repeat (3) tick();
        check_idle_outputs("reset");
        rst_n = 1'b1;
        repeat (4) tick();
        for (int i = 0; i < 256; i++) add_write(i, '0);
        start_sweep();
        wait_done();
        check_sweep("empty", 1025, 0, 0);
        chk("empty_first_addr", first_addr, 0);
        check_idle_outputs("empty_idle");
        for (int k = 0; k < 9; k++) begin
            e = {vecs[k].v, vecs[k].ts, 2'(k), 48'h0A5A_0000_0000 | 48'(k)};
            add_write(5, e);
            now = vecs[k].now;
            thr = vecs[k].thr;
            start_sweep();
            wait_done();
            check_sweep($sformatf("vec%0d", k), 1025 + vecs[k].aged, vecs[k].aged, vecs[k].aged);
            chk($sformatf("vec%0d_entry5", k), mem[5], vecs[k].aged != 0 ? invalidate(e) : e);
        end
        for (int r = 0; r < 3; r++) begin
            now = $urandom();
            thr = (r == 2) ? 32'd0 : 32'($urandom_range(1, 5000));
            n_aged = 0;
            for (int i = 0; i < 256; i++) begin
                mode = $urandom_range(0, 3);
                e[82]    = 1'($urandom_range(0, 1));
                e[81:50] = (mode == 0) ? now - thr : (mode == 1) ? now - thr - 1 : now - 32'($urandom_range(0, 10000));
                e[49:48] = 2'($urandom());
                e[47:0]  = 48'({$urandom(), $urandom()});
                shadow[i] = e;
                add_write(i, e);
                if (ref_aged(e, now, thr)) n_aged++;
            end
            start_sweep();
            wait_done();
            check_sweep($sformatf("rnd%0d", r), 1025 + n_aged, n_aged, n_aged);
            mism = 0;
            for (int i = 0; i < 256; i++)
                if (mem[i] !== (ref_aged(shadow[i], now, thr) ? invalidate(shadow[i]) : shadow[i])) mism++;
            chk($sformatf("rnd%0d_mem_mismatches", r), mism, 0);
        end
        for (int i = 0; i < 256; i++) add_write(i, '0);
        e7 = {1'b1, 32'd0, 2'd1, 48'h7};
        e9 = {1'b1, 32'd0, 2'd2, 48'h9};
        n7 = {1'b1, 32'd4990, 2'd3, 48'h77};
        n9 = {1'b1, 32'd10, 2'd0, 48'h99};
        add_write(7, e7);
        add_write(9, e9);
        now = 32'd5000;
        thr = 32'd100;
        start_sweep();
        found = 0;
        for (int c = 0; c < 200 && found == 0; c++) if (addr == 8'd7) found = 1; else tick();
        chk("coll7_reached", found, 1);
        tick();
        tick();
        add_write(7, n7);
        found = 0;
        for (int c = 0; c < 200 && found == 0; c++) if (wr && addr == 8'd9) found = 1; else tick();
        chk("coll9_reached", found, 1);
        add_addr = 8'd9; add_data = n9; add_wr = 1'b1;
        #1;
        chk("coll9_strobe_suppressed", wr, 0);
        @(posedge clk);
        #1;
        add_wr = 1'b0;
        wait_done();
        check_sweep("coll", 1033, 1, 1);
        chk("coll_age_writes_to_7", wr7_tot - w70, 0);
        chk("coll_entry7", mem[7], n7);
        chk("coll_entry9", mem[9], invalidate(n9));
        for (int i = 0; i < 256; i++) add_write(i, {1'b1, 32'd0, 2'd0, 48'(i)});
        now = 32'h8000_0000;
        thr = 32'd0;
        start_sweep();
        chk("start_clears_count", cnt, 0);
        repeat (300) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done();
        check_sweep("thr0_restart", 1025, 0, 0);
        thr = 32'd1;
        start_sweep();
        wait_done();
        check_sweep("all_aged", 1025 + 256, 256, 256);
        e40 = {1'b1, 32'd0, 2'd2, 48'h40};
        add_write(40, e40);
        now = 32'd1000;
        thr = 32'd10;
        start_sweep();
        found = 0;
        for (int c = 0; c < 400 && found == 0; c++) if (wr && addr == 8'd40) found = 1; else tick();
        chk("rst_wr40_reached", found, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_idle_outputs("async_rst");
        repeat (2) tick();
        chk("rst_entry40_unchanged", mem[40], e40);
        rst_n = 1'b1;
        repeat (4) tick();
        check_idle_outputs("after_rst");
        start_sweep();
        wait_done();
        check_sweep("post_rst", 1026, 1, 1);
        chk("post_rst_first_addr", first_addr, 0);
        chk("post_rst_entry40", mem[40], invalidate(e40));
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
